// File: rtl/shader_seq_ctrl.sv
// shader_seq_ctrl: instruction buffer and program sequencer that feeds the shader core one word per cycle.
module shader_seq_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int LW = 8,
  parameter logic [15:0] NOP_INSTR = 16'h0000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_wdata,
  input  logic          start,
  input  logic [AW:0]   prog_len,
  input  logic [LW-1:0] loop_cnt,
  input  logic          stall,
  input  logic          abort,
  output logic [15:0]   instr,
  output logic          issue_valid,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] pc,
  output logic [LW-1:0] pass
);
  typedef enum logic {IDLE, RUN} state_t;
  localparam logic [AW:0] MAX_LEN = (AW+1)'(DEPTH);
  state_t state, state_nx;
  logic [15:0] mem [DEPTH];
  logic [15:0] instr_nx;
  logic [AW:0] len, len_nx, len_clamp;
  logic [LW-1:0] loop, loop_nx, pass_nx;
  logic [AW-1:0] pc_nx;
  logic issue_nx, done_nx, fin, fin_nx, last_word;
  assign len_clamp = prog_len > MAX_LEN ? MAX_LEN : prog_len;
  assign last_word = {1'b0, pc} == len - 1'b1;
  assign busy = state == RUN;
  always_ff @(posedge clk)
    if (prog_we && state == IDLE) mem[prog_addr] <= prog_wdata;
  always_comb begin
    state_nx = state;
    len_nx = len;
    loop_nx = loop;
    pc_nx = pc;
    pass_nx = pass;
    instr_nx = NOP_INSTR;
    issue_nx = 1'b0;
    fin_nx = 1'b0;
    done_nx = fin;
    if (state == IDLE) begin
      if (start) begin
        len_nx = len_clamp;
        loop_nx = loop_cnt;
        pc_nx = '0;
        pass_nx = '0;
        state_nx = len_clamp == '0 ? IDLE : RUN;
        done_nx = fin | (len_clamp == '0);
      end
    end else if (abort) begin
      state_nx = IDLE;
      pc_nx = '0;
      pass_nx = '0;
    end else if (!stall) begin
      instr_nx = mem[pc];
      issue_nx = 1'b1;
      if (!last_word) pc_nx = pc + 1'b1;
      else if (pass < loop) begin
        pc_nx = '0;
        pass_nx = pass + 1'b1;
      end else begin
        // done follows one cycle after the last word so it never overlaps issue
        state_nx = IDLE;
        fin_nx = 1'b1;
        pc_nx = '0;
        pass_nx = '0;
      end
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      len <= '0;
      loop <= '0;
      pc <= '0;
      pass <= '0;
      instr <= NOP_INSTR;
      issue_valid <= 1'b0;
      done <= 1'b0;
      fin <= 1'b0;
    end else begin
      state <= state_nx;
      len <= len_nx;
      loop <= loop_nx;
      pc <= pc_nx;
      pass <= pass_nx;
      instr <= instr_nx;
      issue_valid <= issue_nx;
      done <= done_nx;
      fin <= fin_nx;
    end
endmodule

// File: tb/tb_shader_seq_ctrl.sv
// tb_shader_seq_ctrl: table of run configurations checked against a word scoreboard, plus abort/reset sequences.
module tb_shader_seq_ctrl;
  localparam logic [15:0] NOP = 16'h0000;
  typedef struct {int len; int loop; int st_at; int st_n; int exp_cyc;} vec_t;
  logic clk = 0, rst_n = 1, prog_we = 0, start = 0, stall = 0, abort = 0;
  logic [3:0] prog_addr = 0;
  logic [15:0] prog_wdata = 0;
  logic [4:0] prog_len = 0;
  logic [7:0] loop_cnt = 0;
  logic [15:0] instr;
  logic issue_valid, busy, done;
  logic [3:0] pc;
  logic [7:0] pass;
  logic [15:0] mdl [16];
  logic [15:0] exp_q [$];
  vec_t vecs [9];
  int total = 0, bad = 0;

  shader_seq_ctrl dut (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .start(start), .prog_len(prog_len), .loop_cnt(loop_cnt), .stall(stall), .abort(abort),
    .instr(instr), .issue_valid(issue_valid), .busy(busy), .done(done), .pc(pc), .pass(pass)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (rst_n && issue_valid) begin
      if (exp_q.size() == 0) chk("extra_issue", 32'(instr), 32'hffff_ffff);
      else chk("instr", 32'(instr), 32'(exp_q.pop_front()));
    end

  task automatic load(input int a, input logic [15:0] d);
    prog_we = 1;
    prog_addr = 4'(a);
    prog_wdata = d;
    tick;
    prog_we = 0;
    mdl[a] = d;
  endtask

  task automatic run(input vec_t v);
    int elen = v.len > 16 ? 16 : v.len;
    int tot = elen * (v.loop + 1);
    int iss = 0, sc = 0, cyc = 0;
    for (int k = 0; k < tot; k++) exp_q.push_back(mdl[k % elen]);
    start = 1;
    prog_len = 5'(v.len);
    loop_cnt = 8'(v.loop);
    tick;
    start = 0;
    prog_we = 0;
    chk("busy_start", 32'(busy), 32'(elen > 0));
    while (!done && cyc < 3000) begin
      stall = (iss == v.st_at && sc < v.st_n);
      if (stall) sc++;
      tick;
      cyc++;
      if (issue_valid) begin
        iss++;
        chk("pc", 32'(pc), 32'(iss < tot ? iss % elen : 0));
        chk("pass", 32'(pass), 32'(iss < tot ? iss / elen : 0));
      end else if (busy) begin
        chk("stall_pc", 32'(pc), 32'(iss % elen));
        chk("stall_instr", 32'(instr), 32'(NOP));
      end
    end
    stall = 0;
    chk("cycles", 32'(cyc), 32'(v.exp_cyc));
    chk("issues", 32'(iss), 32'(tot));
    chk("done_instr", 32'(instr), 32'(NOP));
    chk("done_valid", 32'(issue_valid), 0);
    chk("done_busy", 32'(busy), 0);
    tick;
    chk("done_pulse", 32'(done), 0);
    chk("q_empty", 32'(exp_q.size()), 0);
  endtask

  initial begin
    int cyc;
    vecs[0] = '{4, 0, -1, 0, 5};
    vecs[1] = '{4, 2, -1, 0, 13};
    vecs[2] = '{4, 0, 2, 3, 8};
    vecs[3] = '{0, 0, -1, 0, 0};
    vecs[4] = '{1, 0, -1, 0, 2};
    vecs[5] = '{2, 3, 1, 1, 10};
    vecs[6] = '{16, 1, 5, 2, 35};
    vecs[7] = '{20, 0, -1, 0, 17};
    vecs[8] = '{3, 1, 0, 2, 9};
    #2 rst_n = 0;
    #1;
    chk("rst_instr", 32'(instr), 32'(NOP));
    chk("rst_valid", 32'(issue_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_pc", 32'(pc), 0);
    chk("rst_pass", 32'(pass), 0);
    tick;
    rst_n = 1;
    for (int i = 0; i < 16; i++) load(i, 16'(32'h1111 * (i + 1)));
    stall = 1;
    abort = 1;
    tick;
    stall = 0;
    abort = 0;
    chk("idle_ctl_busy", 32'(busy), 0);
    chk("idle_ctl_done", 32'(done), 0);
    for (int i = 0; i < 9; i++) run(vecs[i]);
    exp_q.delete();
    for (int k = 0; k < 12; k++) exp_q.push_back(mdl[k % 4]);
    prog_len = 4;
    loop_cnt = 2;
    start = 1;
    tick;
    start = 0;
    prog_we = 1;
    prog_addr = 0;
    prog_wdata = 16'hdead;
    cyc = 0;
    while (!(pass == 1 && pc == 2) && cyc < 100) begin
      tick;
      cyc++;
    end
    chk("abort_reach", 32'(cyc < 100), 1);
    abort = 1;
    tick;
    abort = 0;
    prog_we = 0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_valid", 32'(issue_valid), 0);
    chk("abort_instr", 32'(instr), 32'(NOP));
    chk("abort_pc", 32'(pc), 0);
    chk("abort_pass", 32'(pass), 0);
    chk("abort_done", 32'(done), 0);
    tick;
    chk("abort_done2", 32'(done), 0);
    exp_q.delete();
    run(vecs[0]);
    prog_we = 1;
    prog_addr = 0;
    prog_wdata = 16'ha5a5;
    mdl[0] = 16'ha5a5;
    run(vecs[0]);
    for (int k = 0; k < 24; k++) exp_q.push_back(mdl[k % 4]);
    prog_len = 4;
    loop_cnt = 5;
    start = 1;
    tick;
    start = 0;
    tick;
    tick;
    #2 rst_n = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_valid", 32'(issue_valid), 0);
    chk("mid_rst_instr", 32'(instr), 32'(NOP));
    chk("mid_rst_done", 32'(done), 0);
    chk("mid_rst_pc", 32'(pc), 0);
    chk("mid_rst_pass", 32'(pass), 0);
    exp_q.delete();
    tick;
    rst_n = 1;
    run(vecs[1]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/shader_seq_ctrl.md
Name: shader_seq_ctrl

Overview:
- Program sequencer for the shader core.
- Holds a small instruction buffer loaded over a write port. On a start command it issues the stored program to the core one instruction per cycle, repeating it a programmable number of passes.
- Drives the core's 16-bit instruction input. The core writes back every cycle, so the block presents a harmless NOP whenever it is not issuing.
- Supports stall (hold issue), abort, and busy/done status.

Parameters:
- DEPTH, 16: instruction buffer entries (power of 2, ≥2).
- AW, 4: address width, log2(DEPTH).
- LW, 8: loop-count width.
- NOP_INSTR, 16'h0000: instruction word driven when not issuing.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  buffer write strobe; honoured only in IDLE.
- prog_addr  in  AW  buffer write address.
- prog_wdata  in  16  buffer write data.
- start  in  1  begin program; honoured only in IDLE.
- prog_len  in  AW+1  instruction count, 0..DEPTH; sampled on start.
- loop_cnt  in  LW  extra passes; total passes = loop_cnt+1; sampled on start.
- stall  in  1  hold issue while high.
- abort  in  1  terminate the run.
- instr  out  16  instruction to the core (registered).
- issue_valid  out  1  instr holds a real program word this cycle.
- busy  out  1  state is RUN.
- done  out  1  one-cycle pulse on normal completion.
- pc  out  AW  index of the next word to issue.
- pass  out  LW  current pass number, 0-based.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; instr=NOP_INSTR; issue_valid=0; busy=0; done=0; pc=0; pass=0.
  - Latched len/loop=0.
  - Buffer contents are not reset (undefined until written).
- States: IDLE, RUN. busy=1 exactly when state=RUN.
- IDLE:
  - instr=NOP_INSTR, issue_valid=0.
  - prog_we=1 writes prog_wdata to buf[prog_addr] at the edge.
  - start=1 latches prog_len and loop_cnt, sets pc=0 and pass=0.
  - Then state→RUN, or, if prog_len=0, stays IDLE with done=1 next cycle and no issue.
  - A write and start in the same cycle: the write lands first and is visible to the run.
- RUN, each edge, priority abort > stall > issue:
  - abort=1:
    - state→IDLE; instr=NOP_INSTR; issue_valid=0; pc=0; pass=0; done stays 0.
  - stall=1:
    - instr=NOP_INSTR, issue_valid=0; pc and pass hold.
  - Otherwise:
    - instr←buf[pc], issue_valid=1.
    - If pc<len-1: pc←pc+1.
    - Else if pass<loop: pc←0, pass←pass+1 (wrap, no bubble).
    - Else: final issue; state→IDLE at this edge; done=1 next cycle; pc←0, pass←0.
- Latency:
  - start sampled at edge T; first word buf[0] on instr after edge T+1.
  - Total issue cycles = len×(loop_cnt+1) plus stall cycles.
  - done asserts the cycle after the final issue_valid cycle, so instr=NOP_INSTR when done=1.
- Ignored inputs:
  - prog_we during RUN is ignored (buffer is stable while running).
  - start during RUN is ignored.
  - abort and stall in IDLE have no effect.
- prog_len>DEPTH is clamped to DEPTH. pc never exceeds len-1.
- done is high for exactly one cycle. It is never asserted on abort or reset.
- Reset mid-run: immediate return to the reset values above.

Test Plan:
- Load buf[0..3]=16'h1111,2222,3333,4444; start with prog_len=4, loop_cnt=0.
  -> instr sequence 1111,2222,3333,4444 on 4 consecutive cycles with issue_valid=1.
  -> Then done=1 for one cycle, busy=0, instr=0000.
- Same program with loop_cnt=2.
  -> 12 consecutive issues; pass goes 0→1→2; pc wraps 3→0 with no bubble.
  -> done once after the 12th issue.
- Run with stall=1 held for 3 cycles after the second issue.
  -> instr=NOP_INSTR, issue_valid=0, pc=2 held for 3 cycles.
  -> Resumes with 3333; total run = 7 cycles.
- abort asserted during pass 1, pc=2.
  -> Next cycle IDLE, busy=0, instr=NOP, pc=0, pass=0, no done pulse.
  -> A subsequent start runs normally from buf[0].
- start with prog_len=0.
  -> No issue_valid; done=1 the next cycle; busy stays 0.
- prog_we to addr 0 during RUN.
  -> buf[0] unchanged (verify on the next run).
- rst_n pulled low mid-run.
  -> All outputs at reset values asynchronously.
